// File: rtl/mdio_slave_regs.sv
// Clause-22 MDIO responder (PHY side) running entirely in the system clock
// domain. MDC and MDIO are oversampled; each synchronized MDC rising edge
// samples one bit and is the only event that advances the frame FSM.
// Exposes NUM_REGS read/write 16-bit registers plus a read-only status word.
module mdio_slave_regs #(
  parameter logic [4:0] PHY_ADDR    = 5'd1,
  parameter int         NUM_REGS    = 8,
  parameter logic [4:0] STATUS_ADDR = 5'd31,
  parameter int         PRE_LEN     = 32
) (
  input  logic                    sys_clk_50,
  input  logic                    sys_rst,
  input  logic                    mdc,
  input  logic                    mdio_i,
  output logic                    mdio_o,
  output logic                    mdio_t,
  input  logic [15:0]             status_in,
  output logic [NUM_REGS*16-1:0]  regs_flat,
  output logic                    wr_strobe,
  output logic [4:0]              wr_addr,
  output logic [15:0]             wr_data,
  output logic                    rd_strobe,
  output logic                    busy
);

  localparam int              PCW     = $clog2(PRE_LEN + 1);
  localparam logic [PCW-1:0]  PRE_MAX = PCW'(PRE_LEN);
  localparam logic [PCW-1:0]  PRE_ONE = PCW'(1);
  localparam logic [PCW-1:0]  PRE_ZERO = PCW'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ST2   = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA1   = 3'd5,
    S_TA2   = 3'd6,
    S_DATA  = 3'd7
  } state_t;

  // Synchronizer and edge-detect registers
  logic mdc_s1_q, mdc_s2_q, mdc_prev_q;
  logic mdio_s1_q, mdio_s2_q;

  // FSM and frame datapath
  state_t                  state_q, state_d;
  logic                    busy_q;
  logic [PCW-1:0]          pre_cnt_q, pre_cnt_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [1:0]              op_q, op_d;
  logic [4:0]              phyad_q, phyad_d;
  logic [4:0]              regad_q, regad_d;
  logic [14:0]             rx_q, rx_d;
  logic [15:0]             tx_q, tx_d;
  logic                    rd_act_q, rd_act_d;
  logic                    mdio_o_q, mdio_o_d;
  logic                    mdio_t_q, mdio_t_d;
  logic [NUM_REGS*16-1:0]  regs_q, regs_d;
  logic                    wr_strobe_q, wr_strobe_d;
  logic [4:0]              wr_addr_q, wr_addr_d;
  logic [15:0]             wr_data_q, wr_data_d;
  logic                    rd_strobe_q, rd_strobe_d;

  // Combinational helpers
  logic        mdc_rise_s;
  logic        bit_s;
  logic        last2_s, last5_s, last16_s;
  logic        phy_match_s, is_read_s, is_write_s;
  logic [4:0]  regad_full_s;
  logic [15:0] wdata_full_s;
  logic [15:0] rd_word_s;

  assign mdc_rise_s   = mdc_s2_q & ~mdc_prev_q;
  assign bit_s        = mdio_s2_q;
  assign last2_s      = (bit_cnt_q == 4'd1);
  assign last5_s      = (bit_cnt_q == 4'd4);
  assign last16_s     = (bit_cnt_q == 4'd15);
  assign phy_match_s  = (phyad_q == PHY_ADDR);
  assign is_read_s    = (op_q == 2'b10);
  assign is_write_s   = (op_q == 2'b01);
  assign regad_full_s = {regad_q[3:0], bit_s};
  assign wdata_full_s = {rx_q, bit_s};

  // Two-flop synchronizers for MDC/MDIO plus a delayed MDC copy for rise detection.
  always_ff @(posedge sys_clk_50) begin
    if (sys_rst) begin
      mdc_s1_q   <= 1'b0;
      mdc_s2_q   <= 1'b0;
      mdc_prev_q <= 1'b0;
      mdio_s1_q  <= 1'b0;
      mdio_s2_q  <= 1'b0;
    end else begin
      mdc_s1_q   <= mdc;
      mdc_s2_q   <= mdc_s1_q;
      mdc_prev_q <= mdc_s2_q;
      mdio_s1_q  <= mdio_i;
      mdio_s2_q  <= mdio_s1_q;
    end
  end

  // Read data mux for the register address whose last bit is being sampled;
  // the status word wins if it overlaps the RW register range.
  always_comb begin
    rd_word_s = 16'h0000;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (regad_full_s == 5'(i)) begin
        rd_word_s = regs_q[i*16 +: 16];
      end else begin
        rd_word_s = rd_word_s;
      end
    end
    if (regad_full_s == STATUS_ADDR) begin
      rd_word_s = status_in;
    end else begin
      rd_word_s = rd_word_s;
    end
  end

  // FSM state register; busy follows the state being entered.
  always_ff @(posedge sys_clk_50) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // FSM next-state logic; only a synchronized MDC rise moves the frame along.
  always_comb begin
    state_d = state_q;
    if (mdc_rise_s) begin
      case (state_q)
        S_IDLE:  state_d = (!bit_s && (pre_cnt_q == PRE_MAX)) ? S_ST2 : S_IDLE;
        S_ST2:   state_d = bit_s ? S_OP : S_IDLE;
        S_OP:    state_d = last2_s ? S_PHYAD : S_OP;
        S_PHYAD: state_d = last5_s ? S_REGAD : S_PHYAD;
        S_REGAD: state_d = last5_s ? S_TA1 : S_REGAD;
        S_TA1:   state_d = S_TA2;
        S_TA2:   state_d = S_DATA;
        S_DATA:  state_d = last16_s ? S_IDLE : S_DATA;
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Per-state datapath: field capture, read latch/shift-out, write commit.
  always_comb begin
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    op_d        = op_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rd_act_d    = rd_act_q;
    mdio_o_d    = mdio_o_q;
    mdio_t_d    = mdio_t_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_strobe_d = 1'b0;
    if (mdc_rise_s) begin
      case (state_q)
        S_IDLE: begin
          bit_cnt_d = 4'd0;
          if (bit_s) begin
            pre_cnt_d = (pre_cnt_q == PRE_MAX) ? PRE_MAX : (pre_cnt_q + PRE_ONE);
          end else begin
            pre_cnt_d = PRE_ZERO;
          end
        end
        S_ST2: begin
          pre_cnt_d = PRE_ZERO;
          bit_cnt_d = 4'd0;
        end
        S_OP: begin
          op_d      = {op_q[0], bit_s};
          bit_cnt_d = last2_s ? 4'd0 : (bit_cnt_q + 4'd1);
        end
        S_PHYAD: begin
          phyad_d   = {phyad_q[3:0], bit_s};
          bit_cnt_d = last5_s ? 4'd0 : (bit_cnt_q + 4'd1);
        end
        S_REGAD: begin
          regad_d   = regad_full_s;
          bit_cnt_d = last5_s ? 4'd0 : (bit_cnt_q + 4'd1);
          // The read word is captured as soon as the address is complete so
          // it is ready before the turnaround.
          if (last5_s && is_read_s && phy_match_s) begin
            rd_act_d    = 1'b1;
            tx_d        = rd_word_s;
            rd_strobe_d = 1'b1;
          end else begin
            rd_act_d    = 1'b0;
          end
        end
        S_TA1: begin
          // Drive the second turnaround bit low only for our own reads.
          if (rd_act_q) begin
            mdio_t_d = 1'b0;
            mdio_o_d = 1'b0;
          end else begin
            mdio_t_d = 1'b1;
            mdio_o_d = 1'b0;
          end
        end
        S_TA2: begin
          bit_cnt_d = 4'd0;
          if (rd_act_q) begin
            mdio_o_d = tx_q[15];
            tx_d     = {tx_q[14:0], 1'b0};
          end else begin
            mdio_o_d = 1'b0;
          end
        end
        S_DATA: begin
          rx_d = wdata_full_s[14:0];
          if (last16_s) begin
            bit_cnt_d = 4'd0;
            pre_cnt_d = PRE_ZERO;
            rd_act_d  = 1'b0;
            mdio_t_d  = 1'b1;
            mdio_o_d  = 1'b0;
            if (is_write_s && phy_match_s) begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = regad_q;
              wr_data_d   = wdata_full_s;
              for (int i = 0; i < NUM_REGS; i++) begin
                if ((regad_q == 5'(i)) && (regad_q != STATUS_ADDR)) begin
                  regs_d[i*16 +: 16] = wdata_full_s;
                end else begin
                  regs_d[i*16 +: 16] = regs_q[i*16 +: 16];
                end
              end
            end else begin
              wr_strobe_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (rd_act_q) begin
              mdio_o_d = tx_q[15];
              tx_d     = {tx_q[14:0], 1'b0};
            end else begin
              mdio_o_d = 1'b0;
            end
          end
        end
        default: begin
          pre_cnt_d = PRE_ZERO;
          bit_cnt_d = 4'd0;
          rd_act_d  = 1'b0;
          mdio_t_d  = 1'b1;
          mdio_o_d  = 1'b0;
        end
      endcase
    end else begin
      wr_strobe_d = 1'b0;
    end
  end

  // Datapath and register-file flops.
  always_ff @(posedge sys_clk_50) begin
    if (sys_rst) begin
      pre_cnt_q   <= PRE_ZERO;
      bit_cnt_q   <= 4'd0;
      op_q        <= 2'b00;
      phyad_q     <= 5'd0;
      regad_q     <= 5'd0;
      rx_q        <= 15'd0;
      tx_q        <= 16'h0000;
      rd_act_q    <= 1'b0;
      mdio_o_q    <= 1'b0;
      mdio_t_q    <= 1'b1;
      regs_q      <= {(NUM_REGS*16){1'b0}};
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= 16'h0000;
      rd_strobe_q <= 1'b0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      op_q        <= op_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rd_act_q    <= rd_act_d;
      mdio_o_q    <= mdio_o_d;
      mdio_t_q    <= mdio_t_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_strobe_q <= rd_strobe_d;
    end
  end

  // The pad is released the moment reset asserts, not a cycle later.
  assign mdio_t    = mdio_t_q | sys_rst;
  assign mdio_o    = mdio_o_q;
  assign regs_flat = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_strobe = rd_strobe_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mdio_slave_regs.sv
// Directed bench for mdio_slave_regs: a table of MDIO frames with
// hand-computed expectations, plus a reset-during-read-data sequence.
module tb_mdio_slave_regs;

  localparam int NREG = 8;

  logic              sys_clk_50 = 1'b0;
  logic              sys_rst;
  logic              mdc;
  logic              mdio_o, mdio_t;
  logic [15:0]       status_in;
  logic [NREG*16-1:0] regs_flat;
  logic              wr_strobe, rd_strobe, busy;
  logic [4:0]        wr_addr;
  logic [15:0]       wr_data;
  logic              master_oe, master_val;
  wire               mdio_line;

  // Bus: DUT drive wins when enabled, else master drive, else pull-up.
  assign mdio_line = (!mdio_t) ? mdio_o : (master_oe ? master_val : 1'b1);

  always #10 sys_clk_50 = ~sys_clk_50;

  mdio_slave_regs #(
    .PHY_ADDR(5'd1), .NUM_REGS(NREG), .STATUS_ADDR(5'd31), .PRE_LEN(32)
  ) dut (
    .sys_clk_50(sys_clk_50), .sys_rst(sys_rst), .mdc(mdc), .mdio_i(mdio_line),
    .mdio_o(mdio_o), .mdio_t(mdio_t), .status_in(status_in), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_strobe(rd_strobe), .busy(busy)
  );

  // Event counters sampled every clock
  int wr_cnt = 0, rd_cnt = 0, drv_cnt = 0, busy_cnt = 0;
  always @(posedge sys_clk_50) begin
    if (wr_strobe) wr_cnt <= wr_cnt + 1;
    if (rd_strobe) rd_cnt <= rd_cnt + 1;
    if (!mdio_t)   drv_cnt <= drv_cnt + 1;
    if (busy)      busy_cnt <= busy_cnt + 1;
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One MDC period: low phase (data set up), rise, high phase, fall.
  task automatic mdc_bit(input logic drv, input logic val, output logic line_s, output logic t_s);
    master_oe  = drv;
    master_val = val;
    repeat (8) @(negedge sys_clk_50);
    line_s = mdio_line;
    t_s    = mdio_t;
    mdc    = 1'b1;
    repeat (8) @(negedge sys_clk_50);
    mdc    = 1'b0;
  endtask

  task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] ra, input logic [15:0] wd, input int ndata,
                           output logic [15:0] rd, output logic ta1_rel, output logic ta2_ok);
    logic [13:0] hdr;
    logic l, t;
    logic rdop;
    hdr  = {2'b01, op, phy, ra};
    rdop = (op == 2'b10);
    rd = 16'h0000; ta1_rel = 1'b0; ta2_ok = 1'b0;
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, 1'b1, l, t);
    for (int i = 13; i >= 0; i--) mdc_bit(1'b1, hdr[i], l, t);
    mdc_bit(!rdop, 1'b1, l, t);
    ta1_rel = t;
    mdc_bit(!rdop, 1'b0, l, t);
    ta2_ok = (t == 1'b0) && (l == 1'b0);
    for (int i = 15; i >= 16 - ndata; i--) begin
      mdc_bit(!rdop, wd[i], l, t);
      rd[i] = l;
    end
    master_oe = 1'b0;
  endtask

  typedef struct {
    int          pre;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [15:0] wd;
    logic [15:0] st;
    logic [15:0] exp_rd;
    int          exp_wr;
    int          exp_rdp;
    logic        exp_drv;
    logic        exp_commit;
    logic        exp_busy;
  } vec_t;

  localparam int NV      = 18;
  localparam int RST_IDX = 15;
  vec_t vecs [NV];

  logic [15:0] mreg [NREG];
  logic [4:0]  exp_waddr;
  logic [15:0] exp_wdata;

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f = 128'h0;
    for (int k = 0; k < NREG; k++) f[k*16 +: 16] = mreg[k];
    return f;
  endfunction

  // Read of REGAD 3 interrupted by reset part-way through the data phase.
  task automatic reset_mid_frame();
    logic [15:0] rd;
    logic t1, t2, l, t;
    int w0, r0, d0;
    run_frame(32, 2'b10, 5'd1, 5'd3, 16'h0000, 8, rd, t1, t2);
    chk("rst_pre_upper_byte", {120'h0, rd[15:8]}, 128'hA5);
    chk("rst_pre_driving", {127'h0, mdio_t}, 128'h0);
    sys_rst = 1'b1;
    #1;
    chk("rst_mdio_t_immediate", {127'h0, mdio_t}, 128'h1);
    @(negedge sys_clk_50);
    chk("rst_mdio_t_next", {127'h0, mdio_t}, 128'h1);
    chk("rst_regs_zero", regs_flat, 128'h0);
    chk("rst_busy", {127'h0, busy}, 128'h0);
    chk("rst_wr_addr", {123'h0, wr_addr}, 128'h0);
    @(negedge sys_clk_50);
    sys_rst = 1'b0;
    w0 = wr_cnt; r0 = rd_cnt; d0 = drv_cnt;
    for (int i = 0; i < 8; i++) mdc_bit(1'b0, 1'b1, l, t);
    repeat (8) @(negedge sys_clk_50);
    chk("rst_tail_no_drive", 128'(drv_cnt - d0), 128'h0);
    chk("rst_tail_no_strobe", 128'((wr_cnt - w0) + (rd_cnt - r0)), 128'h0);
    chk("rst_tail_busy", {127'h0, busy}, 128'h0);
    for (int k = 0; k < NREG; k++) mreg[k] = 16'h0000;
    exp_waddr = 5'd0;
    exp_wdata = 16'h0000;
  endtask

  initial begin
    logic [15:0] rd;
    logic t1, t2;
    int w0, r0, d0, b0;
    //           pre op     phy    ra      wd        st        exp_rd  wr rdp drv cmt bsy
    vecs[0]  = '{32, 2'b01, 5'd1, 5'd3,  16'hA5C3, 16'h0000, 16'h0000, 1, 0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{32, 2'b10, 5'd1, 5'd3,  16'h0000, 16'h0000, 16'hA5C3, 0, 1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{32, 2'b10, 5'd1, 5'd31, 16'h0000, 16'h1234, 16'h1234, 0, 1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{32, 2'b01, 5'd1, 5'd31, 16'hFFFF, 16'h1234, 16'h0000, 1, 0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{32, 2'b10, 5'd2, 5'd3,  16'h0000, 16'h0000, 16'hFFFF, 0, 0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{32, 2'b11, 5'd1, 5'd3,  16'h0000, 16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{31, 2'b01, 5'd1, 5'd3,  16'h1111, 16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32, 2'b10, 5'd1, 5'd9,  16'h0000, 16'h0000, 16'h0000, 0, 1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{32, 2'b01, 5'd1, 5'd0,  16'h8001, 16'h0000, 16'h0000, 1, 0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{32, 2'b01, 5'd1, 5'd7,  16'h7FFE, 16'h0000, 16'h0000, 1, 0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{32, 2'b01, 5'd1, 5'd8,  16'hBEEF, 16'h0000, 16'h0000, 1, 0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{32, 2'b00, 5'd1, 5'd0,  16'h5555, 16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{32, 2'b10, 5'd1, 5'd7,  16'h0000, 16'h0000, 16'h7FFE, 0, 1, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{32, 2'b10, 5'd1, 5'd0,  16'h0000, 16'h0000, 16'h8001, 0, 1, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{32, 2'b10, 5'd1, 5'd3,  16'h0000, 16'h0000, 16'hA5C3, 0, 1, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{32, 2'b10, 5'd1, 5'd3,  16'h0000, 16'h0000, 16'h0000, 0, 1, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{32, 2'b01, 5'd1, 5'd5,  16'h3C5A, 16'h0000, 16'h0000, 1, 0, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{32, 2'b10, 5'd1, 5'd5,  16'h0000, 16'h0000, 16'h3C5A, 0, 1, 1'b1, 1'b0, 1'b1};

    for (int k = 0; k < NREG; k++) mreg[k] = 16'h0000;
    exp_waddr = 5'd0;
    exp_wdata = 16'h0000;

    sys_rst = 1'b1; mdc = 1'b0; master_oe = 1'b0; master_val = 1'b1; status_in = 16'h0000;
    repeat (5) @(negedge sys_clk_50);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk_50);
    chk("reset_mdio_t", {127'h0, mdio_t}, 128'h1);
    chk("reset_mdio_o", {127'h0, mdio_o}, 128'h0);
    chk("reset_regs", regs_flat, 128'h0);
    chk("reset_strobes", {126'h0, wr_strobe, rd_strobe}, 128'h0);
    chk("reset_wr_addr_data", {107'h0, wr_addr, wr_data}, 128'h0);
    chk("reset_busy", {127'h0, busy}, 128'h0);

    for (int i = 0; i < NV; i++) begin
      if (i == RST_IDX) reset_mid_frame();
      status_in = vecs[i].st;
      w0 = wr_cnt; r0 = rd_cnt; d0 = drv_cnt; b0 = busy_cnt;
      run_frame(vecs[i].pre, vecs[i].op, vecs[i].phy, vecs[i].ra, vecs[i].wd, 16, rd, t1, t2);
      repeat (8) @(negedge sys_clk_50);
      if (vecs[i].exp_wr != 0) begin
        exp_waddr = vecs[i].ra;
        exp_wdata = vecs[i].wd;
      end
      if (vecs[i].exp_commit) mreg[vecs[i].ra[2:0]] = vecs[i].wd;
      chk($sformatf("v%0d_wr_pulses", i), 128'(wr_cnt - w0), 128'(vecs[i].exp_wr));
      chk($sformatf("v%0d_rd_pulses", i), 128'(rd_cnt - r0), 128'(vecs[i].exp_rdp));
      chk($sformatf("v%0d_drive_seen", i), {127'h0, (drv_cnt != d0)}, {127'h0, vecs[i].exp_drv});
      chk($sformatf("v%0d_busy_seen", i), {127'h0, (busy_cnt != b0)}, {127'h0, vecs[i].exp_busy});
      chk($sformatf("v%0d_released_after", i), {127'h0, mdio_t}, 128'h1);
      chk($sformatf("v%0d_idle_after", i), {127'h0, busy}, 128'h0);
      chk($sformatf("v%0d_wr_addr", i), {123'h0, wr_addr}, {123'h0, exp_waddr});
      chk($sformatf("v%0d_wr_data", i), {112'h0, wr_data}, {112'h0, exp_wdata});
      chk($sformatf("v%0d_regs", i), regs_flat, model_flat());
      if (vecs[i].op == 2'b10) begin
        chk($sformatf("v%0d_rdata", i), {112'h0, rd}, {112'h0, vecs[i].exp_rd});
      end
      if (vecs[i].exp_drv) begin
        chk($sformatf("v%0d_ta1_released", i), {127'h0, t1}, 128'h1);
        chk($sformatf("v%0d_ta2_low", i), {127'h0, t2}, 128'h1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
